// File: rtl/x_mod_m_seq.sv
// -----------------------------------------------------------------------------
// x_mod_m_seq
//
// Iterative residue reducer: R = X mod m.
// X is consumed MSB-first, CHUNK bits per clock. Each clock applies CHUNK
// unrolled radix-2 shift-subtract steps to the running residue.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   Once out_valid is raised, out_valid, r_out and err stay stable until
//   out_ready is seen high at an edge.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset; aborts any operation in flight
//   in_valid   operand valid
//   in_ready   block can accept an operand (IDLE only)
//   x_in       operand X (X_W bits)
//   m_sel      0 = use MOD_DEFAULT, 1 = use m_in
//   m_in       runtime modulus, sampled only on accept
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
//   r_out      residue, < m when err = 0
//   err        qualified by out_valid; 1 when the selected modulus was 0
//
// The FSM state register state_q is visible for hierarchical checkers.
// -----------------------------------------------------------------------------
module x_mod_m_seq #(
    parameter int X_W         = 500,
    parameter int R_W         = 10,
    parameter int CHUNK       = 10,
    parameter int MOD_DEFAULT = 997
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [X_W-1:0] x_in,
    input  logic           m_sel,
    input  logic [R_W-1:0] m_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [R_W-1:0] r_out,
    output logic           err
);

    localparam int NCHUNK = (X_W + CHUNK - 1) / CHUNK;
    localparam int SR_W   = NCHUNK * CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);
    localparam logic [R_W-1:0]   MOD_DEF  = R_W'(MOD_DEFAULT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [R_W-1:0]   m_q, m_d;
    logic [R_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [R_W-1:0]   r_out_q, r_out_d;
    logic             err_q, err_d;

    logic [R_W-1:0]   m_pick;
    logic [R_W-1:0]   acc_step;

    // CHUNK radix-2 steps: r = 2r + b, then one conditional subtract.
    // Since r < m before each step, 2r + b < 2m, so one subtract suffices
    // and R_W+1 bits hold the intermediate without overflow.
    function automatic logic [R_W-1:0] reduce_chunk(
        input logic [R_W-1:0]   acc,
        input logic [CHUNK-1:0] bits,
        input logic [R_W-1:0]   m
    );
        logic [R_W:0]   t;
        logic [R_W-1:0] r;
        r = acc;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            t = {r, bits[i]};
            if (t >= {1'b0, m}) begin
                t = t - {1'b0, m};
            end
            r = t[R_W-1:0];
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        m_d      = m_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        r_out_d  = r_out_q;
        err_d    = err_q;
        m_pick   = m_sel ? m_in : MOD_DEF;
        acc_step = reduce_chunk(acc_q, sr_q[SR_W-1 -: CHUNK], m_q);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Zero-extend at the MSB end so the first chunk is aligned.
                    sr_d  = SR_W'(x_in);
                    m_d   = m_pick;
                    acc_d = '0;
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (m_pick == '0) begin
                        // Modulus 0 is undefined: report it without running.
                        r_out_d = '0;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                sr_d  = sr_q << CHUNK;
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    r_out_d = acc_step;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Retirement goes to IDLE; a new accept needs a later edge.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            r_out_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            r_out_q <= r_out_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign r_out     = r_out_q;
    assign err       = err_q;

endmodule
